// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding ibus requests feeding a registered IF/ID slot with a one-entry skid buffer.
// Optional build macro FETCH_ALIGN_CHK_EN adds the misaligned-branch ERR state and fetch_err_o.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
`ifdef FETCH_ALIGN_CHK_EN
    output logic        fetch_err_o,
`endif
    output logic [2:0]  dbg_state
);

    // Handshakes: ibus_req_o/ibus_addr_o stay stable until ibus_gnt_i, which completes the
    // transfer with ibus_rdata_i in the same cycle; the IF/ID slot (if_valid_o) is consumed
    // on any clock edge where stall_i is low.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        DROP  = 3'd3
`ifdef FETCH_ALIGN_CHK_EN
        ,
        ERR   = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] if_pc_d, if_inst_d;
    logic        if_valid_d;
    logic [31:0] branch_tgt;
    logic [31:0] land_pc;
    state_t      land_state;

`ifdef FETCH_ALIGN_CHK_EN
    assign branch_tgt  = branch_target_i;
    assign land_state  = (land_pc[1:0] != 2'b00) ? ERR : FETCH;
    assign fetch_err_o = (state_q == ERR);
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^branch_target_i[1:0];
    assign branch_tgt     = {branch_target_i[31:2], 2'b00};
    assign land_state     = FETCH;
`endif

    // Where a redirect lands: a fresh branch wins over the one parked while dropping.
    assign land_pc = branch_flag_i ? branch_tgt : tgt_q;

    assign ibus_req_o  = (state_q == FETCH) || (state_q == DROP);
    assign ibus_addr_o = pc_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if_pc_d     = if_pc_o;
        if_inst_d   = if_inst_o;
        if_valid_d  = if_valid_o;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                pc_d    = RESET_PC;
            end
            FETCH: begin
                if (branch_flag_i) begin
                    if_valid_d = 1'b0;
                    if (ibus_gnt_i) begin
                        state_d = land_state;
                        pc_d    = land_pc;
                    end else begin
                        state_d = DROP;
                        tgt_d   = branch_tgt;
                    end
                end else if (ibus_gnt_i) begin
                    pc_d = pc_q + 32'd4;
                    if (stall_i) begin
                        state_d     = HOLD;
                        skid_pc_d   = pc_q;
                        skid_inst_d = ibus_rdata_i;
                    end else begin
                        if_pc_d    = pc_q;
                        if_inst_d  = ibus_rdata_i;
                        if_valid_d = 1'b1;
                    end
                end else if (!stall_i) begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (branch_flag_i) begin
                    if_valid_d = 1'b0;
                    state_d    = land_state;
                    pc_d       = land_pc;
                end else if (!stall_i) begin
                    if_pc_d    = skid_pc_q;
                    if_inst_d  = skid_inst_q;
                    if_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                // The granted word belongs to the abandoned path and is discarded.
                if (branch_flag_i) if_valid_d = 1'b0;
                if (ibus_gnt_i) begin
                    state_d = land_state;
                    pc_d    = land_pc;
                end else if (branch_flag_i) begin
                    tgt_d = branch_tgt;
                end
            end
`ifdef FETCH_ALIGN_CHK_EN
            ERR: begin
                if (branch_flag_i) begin
                    if_valid_d = 1'b0;
                    state_d    = land_state;
                    pc_d       = land_pc;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            tgt_q       <= RESET_PC;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
            if_pc_o     <= 32'd0;
            if_inst_o   <= 32'd0;
            if_valid_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            if_pc_o     <= if_pc_d;
            if_inst_o   <= if_inst_d;
            if_valid_o  <= if_valid_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: straight-line steps with immediate assertions against hand-computed values.
// Exercises the FETCH_ALIGN_CHK_EN branch of the design when that macro is defined.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic [2:0]  dbg_state;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fetch_err_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .ibus_req_o      (ibus_req_o),
        .ibus_addr_o     (ibus_addr_o),
        .ibus_gnt_i      (ibus_gnt_i),
        .ibus_rdata_i    (ibus_rdata_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o),
`ifdef FETCH_ALIGN_CHK_EN
        .fetch_err_o     (fetch_err_o),
`endif
        .dbg_state       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: each word is its address tagged with a marker.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction
    assign ibus_rdata_i = mem(ibus_addr_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic valid);
        chk({tag, ".if_pc"}, if_pc_o, pc);
        chk({tag, ".if_inst"}, if_inst_o, mem(pc));
        chk({tag, ".if_valid"}, {31'd0, if_valid_o}, {31'd0, valid});
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, ibus_req_o}, {31'd0, req});
        if (req) chk({tag, ".addr"}, ibus_addr_o, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'd0;
        ibus_gnt_i      = 1'b1;
        #2;
        // Reset state
        chk("rst.req", {31'd0, ibus_req_o}, 32'd0);
        chk("rst.addr", ibus_addr_o, 32'h0);
        chk("rst.if_pc", if_pc_o, 32'h0);
        chk("rst.if_inst", if_inst_o, 32'h0);
        chk("rst.if_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst.state", {29'd0, dbg_state}, 32'd0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("rst.err", {31'd0, fetch_err_o}, 32'd0);
`endif
        tick();
        tick();

        // Release with grant held high: IDLE for one cycle, then back-to-back fetches
        rst = 1'b1;
        chk("idle.req", {31'd0, ibus_req_o}, 32'd0);
        chk("idle.state", {29'd0, dbg_state}, 32'd0);
        tick();
        chk_bus("first", 1'b1, 32'h0);
        chk("first.valid", {31'd0, if_valid_o}, 32'd0);
        tick();
        chk_if("seq0", 32'h0, 1'b1);
        chk_bus("seq0", 1'b1, 32'h4);
        tick();
        chk_if("seq1", 32'h4, 1'b1);
        tick();
        chk_if("seq2", 32'h8, 1'b1);
        chk_bus("seq2", 1'b1, 32'hC);

        // Stall raised in a grant cycle for three cycles: word 0xC parks in the skid
        stall_i = 1'b1;
        tick();
        chk_if("stall0", 32'h8, 1'b1);
        chk("stall0.state", {29'd0, dbg_state}, 32'd2);
        chk("stall0.req", {31'd0, ibus_req_o}, 32'd0);
        tick();
        chk_if("stall1", 32'h8, 1'b1);
        tick();
        chk_if("stall2", 32'h8, 1'b1);
        chk("stall2.req", {31'd0, ibus_req_o}, 32'd0);
        stall_i = 1'b0;
        tick();
        chk_if("unstall0", 32'hC, 1'b1);
        chk_bus("unstall0", 1'b1, 32'h10);
        tick();
        chk_if("unstall1", 32'h10, 1'b1);

        // Branch with same-cycle grant lands directly at 0x8
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h8;
        tick();
        branch_flag_i = 1'b0;
        chk("brg.valid", {31'd0, if_valid_o}, 32'd0);
        chk("brg.state", {29'd0, dbg_state}, 32'd1);
        chk_bus("brg", 1'b1, 32'h8);
        // Request to 0x8 waits; branch to 0x100 arrives while it is pending
        ibus_gnt_i = 1'b0;
        tick();
        chk_bus("wait0", 1'b1, 32'h8);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        chk("drop0.state", {29'd0, dbg_state}, 32'd3);
        chk_bus("drop0", 1'b1, 32'h8);
        tick();
        chk_bus("drop1", 1'b1, 32'h8);
        ibus_gnt_i = 1'b1;
        tick();
        chk_bus("drop_done", 1'b1, 32'h100);
        chk("drop_done.valid", {31'd0, if_valid_o}, 32'd0);
        tick();
        chk_if("tgt100", 32'h100, 1'b1);

        // Branch to 0x200 while holding a stalled skid entry
        stall_i = 1'b1;
        tick();
        chk("hold.state", {29'd0, dbg_state}, 32'd2);
        chk_if("hold", 32'h100, 1'b1);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h200;
        tick();
        branch_flag_i = 1'b0;
        chk("hbr.valid", {31'd0, if_valid_o}, 32'd0);
        chk_bus("hbr", 1'b1, 32'h200);
        tick();
        chk("hbr2.valid", {31'd0, if_valid_o}, 32'd0);
        stall_i = 1'b0;
        tick();
        chk_if("tgt200", 32'h200, 1'b1);
        chk_bus("tgt200", 1'b1, 32'h204);

        // Two branches while dropping: the second target wins
        ibus_gnt_i      = 1'b0;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h300;
        tick();
        chk_bus("lw0", 1'b1, 32'h204);
        branch_target_i = 32'h340;
        tick();
        chk_bus("lw1", 1'b1, 32'h204);
        branch_flag_i = 1'b0;
        ibus_gnt_i    = 1'b1;
        tick();
        chk_bus("lw2", 1'b1, 32'h340);
        chk("lw2.valid", {31'd0, if_valid_o}, 32'd0);

        // Misaligned branch target 0x102
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h102;
        tick();
        branch_flag_i = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        chk("mis.err", {31'd0, fetch_err_o}, 32'd1);
        chk("mis.req", {31'd0, ibus_req_o}, 32'd0);
        chk("mis.state", {29'd0, dbg_state}, 32'd4);
        tick();
        tick();
        chk("mis2.err", {31'd0, fetch_err_o}, 32'd1);
        chk("mis2.req", {31'd0, ibus_req_o}, 32'd0);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h104;
        tick();
        branch_flag_i = 1'b0;
        chk("fix.err", {31'd0, fetch_err_o}, 32'd0);
        chk_bus("fix", 1'b1, 32'h104);
        tick();
        chk_if("fix", 32'h104, 1'b1);
`else
        chk_bus("mis", 1'b1, 32'h100);
        tick();
        chk_if("mis", 32'h100, 1'b1);
`endif

        // Asynchronous reset while a request is outstanding
        stall_i    = 1'b1;
        ibus_gnt_i = 1'b0;
        tick();
        chk("pend.req", {31'd0, ibus_req_o}, 32'd1);
        chk("pend.valid", {31'd0, if_valid_o}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst.req", {31'd0, ibus_req_o}, 32'd0);
        chk("arst.addr", ibus_addr_o, 32'h0);
        chk("arst.if_pc", if_pc_o, 32'h0);
        chk("arst.if_inst", if_inst_o, 32'h0);
        chk("arst.if_valid", {31'd0, if_valid_o}, 32'd0);
        chk("arst.state", {29'd0, dbg_state}, 32'd0);
        stall_i    = 1'b0;
        ibus_gnt_i = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk_bus("restart", 1'b1, 32'h0);
        chk("restart.valid", {31'd0, if_valid_o}, 32'd0);
        tick();
        chk_if("restart", 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
